// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display encoder and the scan reader.
// Segment vectors are ordered abcdefg, with a in bit 6.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0 = 7'b1111110;
    localparam seg_t SEG_1 = 7'b0110000;
    localparam seg_t SEG_2 = 7'b1101101;
    localparam seg_t SEG_3 = 7'b1111001;
    localparam seg_t SEG_4 = 7'b0110011;
    localparam seg_t SEG_5 = 7'b1011011;
    localparam seg_t SEG_6 = 7'b1011111;
    localparam seg_t SEG_7 = 7'b1110000;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1111011;

    localparam logic [3:0] SEG_INVALID_CODE = 4'hF;
    localparam int NUM_DIGITS = 4;

    typedef enum logic {
        COLLECT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [3:0] en;
        seg_t       seg;
    } sample_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the BCD-to-7-segment encoder table.
// Unknown patterns map to the invalid code and raise the invalid flag.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       invalid
);

    always_comb begin
        code    = SEG_INVALID_CODE;
        invalid = 1'b0;
        case (seg)
            SEG_0:   code = 4'd0;
            SEG_1:   code = 4'd1;
            SEG_2:   code = 4'd2;
            SEG_3:   code = 4'd3;
            SEG_4:   code = 4'd4;
            SEG_5:   code = 4'd5;
            SEG_6:   code = 4'd6;
            SEG_7:   code = 4'd7;
            SEG_8:   code = 4'd8;
            SEG_9:   code = 4'd9;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 4-digit 7-segment bus back into BCD digits and
// publishes each complete scan frame through a valid/ready handshake.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic [3:0] dig_en,
    input  logic       out_ready,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] err,
    output logic       out_valid,
    output logic       overrun
);

    localparam logic [7:0] STABLE = STABLE_CYCLES[7:0];

    sample_t    smp_in;
    sample_t    smp;
    logic [7:0] cnt;
    logic       seen;
    logic       at_stable;
    logic       capture;
    logic [1:0] cap_idx;

    logic [3:0] dec_code;
    logic       dec_bad;

    logic [3:0][3:0] slot;
    logic [3:0][3:0] slot_n;
    logic [3:0]      slot_err;
    logic [3:0]      err_n;
    logic [3:0]      got;
    logic [3:0]      got_n;
    logic            publish;
    logic            accept;

    state_t state;
    state_t state_n;

    assign smp_in.en  = dig_en;
    assign smp_in.seg = {a, b, c, d, e, f, g};

    // seen remembers that cnt was already saturated, so a long run fires once
    always_ff @(posedge clk) begin
        if (rst) begin
            smp  <= '0;
            cnt  <= '0;
            seen <= 1'b0;
        end else begin
            smp  <= smp_in;
            seen <= at_stable;
            if (smp_in != smp) begin
                cnt <= '0;
            end else if (cnt < STABLE) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign at_stable = (cnt == STABLE);
    assign capture   = at_stable && !seen && is_onehot(smp.en);
    assign cap_idx   = onehot_index(smp.en);

    seg7_pattern_decode u_dec (
        .seg     (smp.seg),
        .code    (dec_code),
        .invalid (dec_bad)
    );

    always_comb begin
        slot_n = slot;
        err_n  = slot_err;
        got_n  = got;
        if (capture) begin
            slot_n[cap_idx] = dec_code;
            err_n[cap_idx]  = dec_bad;
            got_n           = got | smp.en;
        end
    end

    assign publish = (got_n == 4'b1111);
    assign accept  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= '0;
            slot_err <= '0;
            got      <= '0;
        end else begin
            slot     <= slot_n;
            slot_err <= err_n;
            got      <= publish ? 4'b0000 : got_n;
        end
    end

    // A publish that lands on an accepting cycle is a clean handover
    always_ff @(posedge clk) begin
        if (rst) begin
            d0      <= '0;
            d1      <= '0;
            d2      <= '0;
            d3      <= '0;
            err     <= '0;
            overrun <= 1'b0;
        end else if (publish) begin
            d0      <= slot_n[0];
            d1      <= slot_n[1];
            d2      <= slot_n[2];
            d3      <= slot_n[3];
            err     <= err_n;
            overrun <= overrun | (out_valid & ~out_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            COLLECT: begin
                if (publish) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (!publish && accept) begin
                    state_n = COLLECT;
                end
            end
        endcase
    end

    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomised bench for seg7_scan_reader: a digit-level reference model
// predicts frames into a queue, a monitor checks them on acceptance.
module tb_seg7_scan_reader;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       a, b, c, d, e, f, g;
    logic [3:0] dig_en;
    logic       out_ready;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] err;
    logic       out_valid;
    logic       overrun;

    always #5 clk = ~clk;

    seg7_scan_reader #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .dig_en    (dig_en),
        .out_ready (out_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .err       (err),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] enc [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  err;
        logic        ovr;
    } frame_t;

    frame_t      q[$];
    logic [3:0]  m_got;
    logic [15:0] m_d;
    logic [3:0]  m_err;
    logic        m_ovr;
    logic [10:0] last_v;
    int          run;
    bit          cap_done;
    int          last_k;
    int          rise_cyc = -1;
    logic        prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] ref_dec(input logic [6:0] s);
        logic [4:0] r;
        r = {4'hF, 1'b1};
        for (int i = 0; i < 10; i++)
            if (enc[i] == s) r = {4'(i), 1'b0};
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_got    = '0;
        m_d      = '0;
        m_err    = '0;
        m_ovr    = 1'b0;
        last_v   = '0;
        run      = 0;
        cap_done = 1'b0;
    endtask

    // Apply one bus value for n cycles; acc raises out_ready for exactly
    // the cycle before the publish edge that this value would cause.
    task automatic present(input logic [3:0] en, input logic [6:0] s,
                           input int n, input bit acc = 1'b0);
        logic [10:0] v;
        logic [4:0]  r;
        int          idx;
        frame_t      fr;
        v = {en, s};
        {dig_en, a, b, c, d, e, f, g} = v;
        last_k = cyc + 1;
        if (v == last_v) run += n;
        else begin
            run = n;
            cap_done = 1'b0;
        end
        last_v = v;
        if (run >= S + 1 && !cap_done && $countones(en) == 1) begin
            cap_done = 1'b1;
            idx = 0;
            for (int i = 0; i < 4; i++) if (en[i]) idx = i;
            r = ref_dec(s);
            m_d[idx*4 +: 4] = r[4:1];
            m_err[idx] = r[0];
            m_got[idx] = 1'b1;
            if (m_got == 4'hF) begin
                if (q.size() > 0 && !acc) begin
                    void'(q.pop_back());
                    m_ovr = 1'b1;
                end
                fr.dig = m_d;
                fr.err = m_err;
                fr.ovr = m_ovr;
                q.push_back(fr);
                m_got = '0;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (acc && i == S + 1) out_ready = 1'b1;
            if (acc && i == S + 2) out_ready = 1'b0;
            step();
        end
        if (acc) out_ready = 1'b0;
    endtask

    task automatic do_reset();
        {dig_en, a, b, c, d, e, f, g} = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check("rst_digits", {16'h0, d3, d2, d1, d0}, 32'h0);
        check("rst_err", {28'h0, err}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
    endtask

    task automatic accept_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic rand_frame(input int hold);
        for (int i = 0; i < 4; i++)
            present(4'(1 << i), enc[$urandom_range(0, 9)], hold);
    endtask

    always @(negedge clk) begin
        frame_t fr;
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                rise_cyc = cyc;
                check("valid_rise_expected", {31'h0, q.size() > 0}, 32'h1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("accept_unexpected", 32'h0, 32'h1);
                end else begin
                    fr = q.pop_front();
                    check("frame_digits", {16'h0, d3, d2, d1, d0},
                          {16'h0, fr.dig});
                    check("frame_err", {28'h0, err}, {28'h0, fr.err});
                    check("frame_overrun", {31'h0, overrun}, {31'h0, fr.ovr});
                end
            end
            prev_v = out_valid;
        end
    end

    initial begin
        logic [6:0] pat;
        rst = 1'b1;
        out_ready = 1'b1;
        {dig_en, a, b, c, d, e, f, g} = '0;
        model_reset();
        do_reset();

        present(4'b0001, enc[1], 6);
        present(4'b0010, enc[2], 6);
        present(4'b0100, enc[3], 6);
        present(4'b1000, enc[4], 6);
        repeat (3) step();
        check("t1_latency", rise_cyc, last_k + S + 1);
        check("t1_drained", q.size(), 0);
        check("t1_valid_low", {31'h0, out_valid}, 32'h0);

        for (int p = 0; p < 12; p++) begin
            if (p < 10) pat = enc[p];
            else if (p == 10) pat = 7'b0000000;
            else pat = 7'b1000001;
            for (int i = 0; i < 4; i++)
                present(4'(1 << i), (i == 2) ? pat : enc[$urandom_range(0, 9)],
                        $urandom_range(S + 1, S + 4));
        end
        repeat (3) step();
        check("t2_drained", q.size(), 0);

        present(4'b0001, enc[0], 2);
        present(4'b0001, enc[8], 3);
        present(4'b0001, enc[0], 6);
        present(4'b0001, enc[8], S);
        for (int i = 1; i < 4; i++)
            present(4'(1 << i), enc[$urandom_range(0, 9)], 6);
        repeat (3) step();
        check("t3_drained", q.size(), 0);

        present(4'b0001, enc[5], 6);
        present(4'b0010, enc[6], 6);
        present(4'b0011, enc[7], 20);
        present(4'b0000, 7'b0000000, 20);
        check("t4_no_publish", {31'h0, out_valid}, 32'h0);
        present(4'b0100, enc[9], 6);
        present(4'b1000, enc[1], 6);
        repeat (3) step();
        check("t4_drained", q.size(), 0);

        out_ready = 1'b0;
        rand_frame(6);
        check("t5_a_pending", {31'h0, out_valid}, 32'h1);
        for (int i = 0; i < 3; i++)
            present(4'(1 << i), enc[$urandom_range(0, 9)], 6);
        present(4'b1000, enc[$urandom_range(0, 9)], S + 3, 1'b1);
        check("t5_valid_held", {31'h0, out_valid}, 32'h1);
        check("t5_no_overrun", {31'h0, overrun}, 32'h0);
        accept_one();
        check("t5_valid_drop", {31'h0, out_valid}, 32'h0);

        present(4'b0001, enc[5], 6);
        present(4'b0010, enc[6], 6);
        present(4'b0100, enc[7], 6);
        present(4'b1000, enc[8], 6);
        present(4'b0001, enc[9], 6);
        present(4'b0010, enc[0], 6);
        present(4'b0100, enc[1], 6);
        present(4'b1000, enc[2], 6);
        repeat (2) step();
        check("t6_digits", {16'h0, d3, d2, d1, d0}, 32'h2109);
        check("t6_valid", {31'h0, out_valid}, 32'h1);
        check("t6_overrun", {31'h0, overrun}, 32'h1);
        accept_one();
        check("t6_valid_drop", {31'h0, out_valid}, 32'h0);

        out_ready = 1'b1;
        present(4'b0001, enc[3], 6);
        present(4'b0010, enc[4], 6);
        present(4'b0100, enc[5], 6);
        check("t7_pre_reset_valid", {31'h0, out_valid}, 32'h0);
        do_reset();
        present(4'b1000, enc[6], 6);
        repeat (3) step();
        check("t7_no_stale_publish", {31'h0, out_valid}, 32'h0);
        present(4'b0001, enc[7], 6);
        present(4'b0010, enc[8], 6);
        present(4'b0100, enc[9], 6);
        repeat (3) step();
        check("t7_drained", q.size(), 0);
        check("t7_final_digits", {16'h0, d3, d2, d1, d0}, 32'h6987);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart of the team's BCD-to-7-segment decoder. The block watches a multiplexed 4-digit 7-segment bus (segment lines a–g plus one-hot digit enables), debounces each digit slot, and maps each segment pattern back to a BCD value. When all four digits of a scan frame are captured, it publishes the frame through a valid/ready handshake. It sits on the verification/loopback side of the display path: display-driver outputs in, digit values out to a checker or CPU register.

## Interface
- `STABLE_CYCLES`, default 4: consecutive unchanged sampled cycles required before a digit is captured; legal range 2–255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a, b, c, d, e, f, g` in 1 each: segment lines, active-high.
- `dig_en` in 4: digit enables, active-high; bit i selects digit i.
- `out_ready` in 1: consumer accepts the frame.
- `d0, d1, d2, d3` out 4 each: published BCD digits; reset 0.
- `err` out 4: bit i set when digit i held an unrecognised pattern; reset 0.
- `out_valid` out 1: frame available; reset 0.
- `overrun` out 1: sticky; a frame was overwritten while unacknowledged; reset 0.

## Operation
- Inputs are registered once into the sample register `{dig_en, a..g}` (11 bits).
- Stability counter `cnt` (8 bits):
  - 0 when the sample differs from the previous sample.
  - Otherwise increments, saturating at `STABLE_CYCLES`.
- Capture fires in the single cycle `cnt` reaches `STABLE_CYCLES`, and only if the sampled `dig_en` is exactly one-hot. Zero or multi-hot enables never capture.
- Pattern decode, in segment order `abcdefg`:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111
  - 7 = 1110000
  - 8 = 1111111
  - 9 = 1111011
  - Any other pattern, including all-zero, gives code 4'hF with that digit's pending error bit set.
- A capture writes the slot buffer and pending error bit for the enabled digit, and sets bit i of the `got` mask. Recapturing a digit already in `got` overwrites it (latest wins).
- Publish happens when `got` becomes 4'b1111, including via the current capture:
  - `d0..d3` and `err` load from the slot buffer (same edge as the capture).
  - `out_valid` is set to 1.
  - `got` is cleared.
- Handshake:
  - `out_valid` holds, and outputs stay stable, until a cycle with `out_valid && out_ready`, which clears `out_valid` on the next edge.
- Boundary conditions:
  - Publish while `out_valid && !out_ready`: outputs are overwritten, `out_valid` stays 1, and `overrun` is set.
  - Publish in the same cycle as acceptance (`out_valid && out_ready`): the new frame loads, `out_valid` stays 1, and `overrun` is not set.
- FSM with two states:
  - `COLLECT`: `got` ≠ 1111.
  - `HOLD`: `out_valid` = 1.
  - These are orthogonal: collection continues during `HOLD`.
- `rst` clears the sample registers, `cnt`, `got`, the slot buffer, and all outputs, regardless of frame progress. The first capture after reset requires a full stable run.

## Timing
- An input applied before edge k and held unchanged becomes the sample at edge k. `cnt` reaches `STABLE_CYCLES` at edge k+`STABLE_CYCLES`, so the capture and any publish are visible after edge k+`STABLE_CYCLES`+1.
- One capture per stable run. A digit held for 100 cycles is captured once.
- A glitch of any length below `STABLE_CYCLES` sampled cycles restarts `cnt` and produces no capture.
- Minimum frame latency is 4 × (`STABLE_CYCLES`+1) cycles, with digits presented back-to-back.
- `out_valid` falls one edge after an accepting cycle.
- No combinational path from inputs to outputs.

## Structure
- Package `seg7_pkg`:
  - 7-bit segment pattern constants `SEG_0`…`SEG_9`, shared with the encoder.
  - `SEG_INVALID_CODE` = 4'hF.
  - Typedef `seg_t` (logic [6:0]).
- Sub-module `seg7_pattern_decode`: combinational 7-bit to {4-bit code, error}. This is the exact inverse table of the encoder; the top-level instantiates it once on the sample register.
- The top level holds the sampler, counter, `got` mask, slot buffer, and handshake logic.

## Test plan
- `STABLE_CYCLES`=4; present digits 0:`SEG_1`, 1:`SEG_2`, 2:`SEG_3`, 3:`SEG_4`, 6 cycles each, `out_ready`=1 → `out_valid` pulses once with d0..d3 = 1,2,3,4 and `err` = 0. Check the publish edge equals the last digit's apply edge + 5.
- All 10 legal patterns round-trip through the encoder model onto digit 2 → d2 matches each BCD value. Patterns 0000000 and 1000001 → d2 = F, `err[2]` = 1.
- 3-cycle glitch to `SEG_8` inside a stable `SEG_0` run on digit 0 → no capture of 8; `SEG_0` is captured once the run resumes.
- `dig_en` = 0011 and `dig_en` = 0000 held 20 cycles → no capture, `got` unchanged, `out_valid` stays 0.
- `out_ready`=0 across two full frames (5,6,7,8) then (9,0,1,2) → outputs show 9,0,1,2, `out_valid` = 1, `overrun` = 1. Raising `out_ready` for 1 cycle drops `out_valid`. A frame completing during the accepting cycle → `out_valid` stays 1 and `overrun` is not newly set.
- Assert `rst` for 1 cycle after 3 digits are captured → all outputs 0. A following full frame is required for `out_valid`, with no stale digits from before the reset.
